// File: rtl/frontier_reader_if.sv
// Pop-port and output-stream signals of the frontier reader.
// master = the reader; slave = the frontier plus the downstream stage.
interface frontier_reader_if #(
  parameter int W_D = 32
);
  logic           read_req_valid;
  logic           read_req_ready;
  logic           read_data_valid;
  logic [W_D-1:0] read_node_addr;
  logic [W_D-1:0] read_cost;
  logic           read_empty;
  logic           out_valid;
  logic           out_ready;
  logic [W_D-1:0] out_node_addr;
  logic [W_D-1:0] out_cost;

  modport master (
    output read_req_valid,
    input  read_req_ready, read_data_valid, read_node_addr, read_cost, read_empty,
    output out_valid, out_node_addr, out_cost,
    input  out_ready
  );

  modport slave (
    input  read_req_valid,
    output read_req_ready, read_data_valid, read_node_addr, read_cost, read_empty,
    input  out_valid, out_node_addr, out_cost,
    output out_ready
  );
endinterface

// File: rtl/frontier_reader.sv
// Pop-side initiator for the Dijkstra frontier queue: one pop at a time,
// a 2-entry output FIFO, and empty-with-no-pushes-in-flight termination.
//   state | meaning
//   IDLE  | waiting for start after reset
//   ISSUE | requesting a pop, or counting qualified-empty cycles
//   WAIT  | one pop outstanding, waiting for read_data_valid
//   DONE  | search finished, waiting for a restart
module frontier_reader #(
  parameter int W_D        = 32,
  parameter int EMPTY_WAIT = 4,
  parameter int W_CNT      = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             busy_in,
  frontier_reader_if.master bus,
  output logic             active,
  output logic             done,
  output logic [W_CNT-1:0] pop_count,
  output logic             protocol_err
);

  localparam int W_E = (EMPTY_WAIT > 1) ? $clog2(EMPTY_WAIT) : 1;
  localparam logic [W_E-1:0] EMPTY_LAST = W_E'(EMPTY_WAIT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state, state_next;
  logic [2*W_D-1:0] buf_mem [2];
  logic             buf_head, buf_tail;
  logic [1:0]       buf_count;
  logic [W_E-1:0]   empty_cnt;
  logic             orphan;
  logic             qual_empty, last_empty, issue_fire, start_ok;
  logic             buf_wr, buf_rd;

  assign bus.out_valid = (buf_count != 2'd0);
  assign {bus.out_node_addr, bus.out_cost} = buf_mem[buf_head];
  assign buf_rd = bus.out_valid && bus.out_ready;

  always_comb begin
    state_next         = state;
    bus.read_req_valid = 1'b0;
    active             = 1'b0;
    done               = 1'b0;
    qual_empty         = 1'b0;
    last_empty         = 1'b0;
    issue_fire         = 1'b0;
    start_ok           = 1'b0;
    buf_wr             = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        active             = 1'b1;
        bus.read_req_valid = !bus.read_empty && (buf_count < 2'd2);
        qual_empty         = bus.read_empty && !busy_in && (buf_count == 2'd0);
        last_empty         = qual_empty && (empty_cnt == EMPTY_LAST);
        issue_fire         = bus.read_req_valid && bus.read_req_ready;
        if (issue_fire) state_next = WAIT;
        else if (last_empty) state_next = DONE;
      end
      WAIT: begin
        active = 1'b1;
        if (bus.read_data_valid) begin
          buf_wr     = 1'b1;
          state_next = ISSUE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          start_ok   = 1'b1;
          state_next = ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      buf_mem[0]   <= '0;
      buf_mem[1]   <= '0;
      buf_head     <= 1'b0;
      buf_tail     <= 1'b0;
      buf_count    <= 2'd0;
      empty_cnt    <= '0;
      pop_count    <= '0;
      protocol_err <= 1'b0;
      // Remember an abandoned pop so its late response is not flagged as stray.
      orphan       <= (state == WAIT);
    end else begin
      if (buf_wr) begin
        buf_mem[buf_tail] <= {bus.read_node_addr, bus.read_cost};
        buf_tail          <= ~buf_tail;
      end
      if (buf_rd) buf_head <= ~buf_head;
      if (buf_wr && !buf_rd)      buf_count <= buf_count + 2'd1;
      else if (!buf_wr && buf_rd) buf_count <= buf_count - 2'd1;

      if (start_ok)    pop_count <= '0;
      else if (buf_wr) pop_count <= pop_count + 1'b1;

      if (qual_empty && !last_empty) empty_cnt <= empty_cnt + 1'b1;
      else                           empty_cnt <= '0;

      if (bus.read_data_valid && (state != WAIT)) begin
        if (!orphan) protocol_err <= 1'b1;
        orphan <= 1'b0;
      end else if (issue_fire) begin
        orphan <= 1'b0;
      end
    end
  end

endmodule
